// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_pkg                                              |
// | Description : Shared types and widths for the instruction fetch      |
// |               stage (state encoding, fetched entry record).          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // IDLE : nothing outstanding
  // WAIT : one request outstanding, its response is wanted
  // FLUSH: one request outstanding, its response must be discarded
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_skid                                             |
// | Description : One-entry holding register that parks a fetched        |
// |               instruction while the output register is stalled.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  // Clear wins over load: a flush must never leave a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit                                             |
// | Description : Instruction fetch stage. Owns the fetch PC, keeps at   |
// |               most one memory request in flight, delivers            |
// |               instruction/PC pairs to decode and honours execute     |
// |               redirects by discarding wrong-path work.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  localparam logic [1:0] c_ST_IDLE  = IDLE;
  localparam logic [1:0] c_ST_WAIT  = WAIT;
  localparam logic [1:0] c_ST_FLUSH = FLUSH;
  localparam logic [PC_W-1:0] c_WORD_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  logic [1:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_out;

  logic               w_skid_valid;
  fetch_entry_t       w_skid_entry;
  fetch_entry_t       w_resp_entry;
  logic               w_accept;
  logic               w_resp;
  logic               w_slot_free;
  logic               w_skid_load;
  logic               w_skid_clear;

  // No new request while the skid is occupied, so a response can never
  // arrive with nowhere to go.
  assign imem_req_o   = (r_state == c_ST_IDLE) && !redirect_i && !w_skid_valid;
  assign imem_addr_o  = r_pc;
  assign w_accept     = imem_req_o && imem_ready_i;
  assign w_resp       = (r_state == c_ST_WAIT) && imem_rvalid_i;
  assign w_slot_free  = !r_valid || !stall_i;
  assign w_resp_entry = '{instr: imem_rdata_i, pc: r_req_pc};

  assign w_skid_clear = redirect_i || (w_slot_free && w_skid_valid);
  assign w_skid_load  = !redirect_i && w_resp && !w_slot_free;

  // Request/response sequencing and fetch PC; redirect overrides everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= c_ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else if (redirect_i) begin
      r_pc <= redirect_pc_i & c_WORD_MASK;
      // A response landing in the redirect cycle closes the transaction.
      if (imem_rvalid_i && (r_state != c_ST_IDLE)) begin
        r_state <= c_ST_IDLE;
      end else if (r_state == c_ST_WAIT) begin
        r_state <= c_ST_FLUSH;
      end
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_state  <= c_ST_WAIT;
          end
        end
        c_ST_WAIT, c_ST_FLUSH: begin
          if (imem_rvalid_i) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Output register: refilled from skid first, then from a live response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else if (redirect_i) begin
      r_valid <= 1'b0;
    end else if (w_slot_free) begin
      if (w_skid_valid) begin
        r_valid  <= 1'b1;
        r_instr  <= w_skid_entry.instr;
        r_pc_out <= w_skid_entry.pc;
      end else if (w_resp) begin
        r_valid  <= 1'b1;
        r_instr  <= imem_rdata_i;
        r_pc_out <= r_req_pc;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  fetch_skid u_skid (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_entry (w_resp_entry),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );

  assign valid_o = r_valid;
  assign instr_o = r_instr;
  assign pc_o    = r_pc_out;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                          |
// | Description : Self-checking bench for fetch_unit: scripted cycle     |
// |               table for corner cases, then randomized traffic        |
// |               against a program-order reference model.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = 32'h0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int checks   = 0;
  int failures = 0;
  int cur_row  = 0;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: one response mem_lat cycles after acceptance,
  // data = 32'h1111_0000 + address.
  int          mem_lat = 1;
  bit          pend    = 0;
  int          cnt     = 0;
  logic [31:0] p_addr  = 32'h0;
  bit          acc_s   = 0;
  bit          rv_s    = 0;
  logic [31:0] addr_s  = 32'h0;

  always @(negedge clk) begin
    imem_rvalid_i = pend && (cnt == 0);
    imem_rdata_i  = (pend && (cnt == 0)) ? (32'h1111_0000 + p_addr) : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    #3;
    acc_s  = imem_req_o && imem_ready_i && rst_n_i;
    addr_s = imem_addr_o;
    rv_s   = imem_rvalid_i;
  end

  always @(posedge clk) begin
    if (!rst_n_i) begin
      pend = 0;
    end else begin
      if (rv_s) pend = 0;
      else if (pend && cnt > 0) cnt--;
      if (acc_s) begin
        pend   = 1;
        cnt    = mem_lat - 1;
        p_addr = addr_s;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, cur_row, act, exp);
    end
  endtask

  typedef struct {
    bit          rst_n;
    bit          redirect;
    logic [31:0] rpc;
    bit          stall;
    bit          ready;
    int          lat;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    bit          chk_out;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } step_t;

  step_t tbl[$];

  function automatic step_t mk(bit rst_n, bit rdr, logic [31:0] rpc, bit stall, bit ready,
                               int lat, bit er, logic [31:0] ea, bit ev, bit co,
                               logic [31:0] ep, logic [31:0] ei);
    step_t s;
    s.rst_n = rst_n; s.redirect = rdr; s.rpc = rpc; s.stall = stall; s.ready = ready;
    s.lat = lat; s.exp_req = er; s.exp_addr = ea; s.exp_valid = ev; s.chk_out = co;
    s.exp_pc = ep; s.exp_instr = ei;
    return s;
  endfunction

  task automatic step(input step_t s);
    @(negedge clk);
    rst_n_i       = s.rst_n;
    redirect_i    = s.redirect;
    redirect_pc_i = s.rpc;
    stall_i       = s.stall;
    imem_ready_i  = s.ready;
    mem_lat       = s.lat;
    #2;
    chk("req", {31'h0, imem_req_o}, {31'h0, s.exp_req});
    if (s.exp_req) chk("addr", imem_addr_o, s.exp_addr);
    chk("valid", {31'h0, valid_o}, {31'h0, s.exp_valid});
    if (s.chk_out) begin
      chk("pc", pc_o, s.exp_pc);
      chk("instr", instr_o, s.exp_instr);
    end
  endtask

  // Random-phase reference state
  logic [31:0] next_fetch;
  logic [31:0] exp_deliver;
  logic [31:0] prev_addr;
  bit          prev_stuck;
  int          delivered;

  initial begin
    rst_n_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    stall_i = 1'b0; imem_ready_i = 1'b1;

    //           rst rdr rpc           st rdy lat req addr          v  co pc            instr
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    // zero-wait fetch from reset
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h4,        1, 1, 32'h0,        32'h1111_0000));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    // ready low for three cycles on 0x8
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 1, 1, 32'h8,        1, 1, 32'h4,        32'h1111_0004));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 1, 1, 32'h8,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 1, 1, 32'h8,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h8,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    // stall four cycles: response for 0xC goes to skid, no new request
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 1, 1, 32'hC,        1, 1, 32'h8,        32'h1111_0008));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        1, 1, 32'h8,        32'h1111_0008));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        1, 1, 32'h8,        32'h1111_0008));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        1, 1, 32'h8,        32'h1111_0008));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        1, 1, 32'h8,        32'h1111_0008));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h10,       1, 1, 32'hC,        32'h1111_000C));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    // redirect to 0x100 while waiting on 0x14 (2-cycle memory)
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 2, 1, 32'h14,       1, 1, 32'h10,       32'h1111_0010));
    tbl.push_back(mk(1, 1, 32'h100,      0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h100,      0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    // redirect to 0x203 coincident with response and stall
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 1, 1, 32'h104,      1, 1, 32'h100,      32'h1111_0100));
    tbl.push_back(mk(1, 1, 32'h203,      1, 1, 1, 0, 32'h0,        1, 1, 32'h100,      32'h1111_0100));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h200,      0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h204,      1, 1, 32'h200,      32'h1111_0200));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    // top-of-memory wrap
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 1, 1, 0, 32'h0,       1, 1, 32'h204,      32'h1111_0204));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 3, 1, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'h1110_FFFC));
    // reset pulse mid-WAIT
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 1, 1, 32'h4,        1, 1, 32'h0,        32'h1111_0000));

    for (int i = 0; i < tbl.size(); i++) begin
      cur_row = i;
      step(tbl[i]);
    end

    // Randomized traffic: deliveries must follow program order from the
    // last redirect target (or reset PC), with no gaps or repeats.
    @(negedge clk);
    rst_n_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    next_fetch  = 32'h0;
    exp_deliver = 32'h0;
    prev_stuck  = 0;
    prev_addr   = 32'h0;
    delivered   = 0;
    for (int c = 0; c < 4000; c++) begin
      cur_row = 1000 + c;
      if (c != 0) @(negedge clk);
      rst_n_i      = 1'b1;
      redirect_i   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc_i = $urandom();
      stall_i      = ($urandom_range(0, 99) < 30);
      imem_ready_i = ($urandom_range(0, 99) < 75);
      mem_lat      = $urandom_range(1, 3);
      #2;
      if (prev_stuck && !redirect_i) begin
        chk("hold_req", {31'h0, imem_req_o}, 32'h1);
        chk("hold_addr", imem_addr_o, prev_addr);
      end
      if (redirect_i) chk("req_in_redirect", {31'h0, imem_req_o}, 32'h0);
      else if (imem_req_o) chk("rnd_addr", imem_addr_o, next_fetch);
      if (valid_o && !stall_i) begin
        chk("rnd_pc", pc_o, exp_deliver);
        chk("rnd_instr", instr_o, 32'h1111_0000 + exp_deliver);
        exp_deliver = exp_deliver + 32'd4;
        delivered++;
      end
      prev_stuck = imem_req_o && !imem_ready_i && !redirect_i;
      prev_addr  = imem_addr_o;
      if (redirect_i) begin
        next_fetch  = redirect_pc_i & 32'hFFFF_FFFC;
        exp_deliver = next_fetch;
      end else if (imem_req_o && imem_ready_i) begin
        next_fetch = next_fetch + 32'd4;
      end
    end
    cur_row = 9999;
    chk("progress", {31'h0, (delivered > 200)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
